// File: rtl/rf_wr_arbiter.sv
// ============================================================================
// rf_wr_arbiter: round-robin arbiter for the register file's single write port
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wr_arbiter #(
    parameter int W    = 8,
    parameter int D    = 4,
    parameter int N    = 3,
    parameter int PRIV = 2,
    parameter int RSV0 = 14,
    parameter int RSV1 = 15,
    localparam int LG_W = $clog2(N)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N-1:0]    req,
    input  logic [N*D-1:0]  req_addr,
    input  logic [N*W-1:0]  req_data,
    input  logic            stall,
    output logic [N-1:0]    ack,
    output logic            err,
    output logic            rf_write_en,
    output logic [D-1:0]    rf_waddr,
    output logic [W-1:0]    rf_data_in,
    output logic [LG_W-1:0] last_grant
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [D-1:0]    waddr_q, waddr_d;
    logic [W-1:0]    wdata_q, wdata_d;
    logic [LG_W-1:0] last_grant_q, last_grant_d;

    logic [N-1:0]    ack_now;
    logic [N-1:0]    eligible;
    logic            found;
    logic [LG_W-1:0] winner;
    logic [LG_W-1:0] idx;
    logic [D-1:0]    sel_addr;
    logic [W-1:0]    sel_data;
    logic            reserved;

    always_comb begin
        // A requester being acked right now is masked so its next request waits a turn
        ack_now  = (state_q == ISSUE) ? ack_q : '0;
        eligible = req & ~ack_now & {N{~stall}};

        found  = 1'b0;
        winner = last_grant_q;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = LG_W'((int'(last_grant_q) + k) % N);
            for (int i = 0; i < N; i++) begin
                if (!found && (LG_W'(i) == idx) && eligible[i]) begin
                    found  = 1'b1;
                    winner = idx;
                end
            end
        end

        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (LG_W'(i) == winner) begin
                sel_addr = req_addr[i*D +: D];
                sel_data = req_data[i*W +: W];
            end
        end

        reserved = ((sel_addr == D'(RSV0)) || (sel_addr == D'(RSV1)))
                   && (winner != LG_W'(PRIV));

        state_d      = IDLE;
        ack_d        = '0;
        err_d        = 1'b0;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;

        if (found) begin
            state_d      = ISSUE;
            ack_d        = N'(1) << winner;
            err_d        = reserved;
            we_d         = ~reserved;
            waddr_d      = sel_addr;
            wdata_d      = sel_data;
            last_grant_d = winner;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            last_grant_q <= LG_W'(N - 1);
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ack         = ack_q;
    assign err         = err_q;
    assign rf_write_en = we_q;
    assign rf_waddr    = waddr_q;
    assign rf_data_in  = wdata_q;
    assign last_grant  = last_grant_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
// ============================================================================
// tb_rf_wr_arbiter: scoreboard bench for rf_wr_arbiter with a reg_file model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wr_arbiter;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 3;

    logic           CLK;
    logic           RST_N;
    logic [N-1:0]   req;
    logic [N*D-1:0] req_addr;
    logic [N*W-1:0] req_data;
    logic           stall;
    logic [N-1:0]   ack;
    logic           err;
    logic           rf_write_en;
    logic [D-1:0]   rf_waddr;
    logic [W-1:0]   rf_data_in;
    logic [1:0]     last_grant;

    typedef struct {
        logic [N-1:0] ack;
        logic         we;
        logic         err;
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic [W-1:0] rf_mem [0:(1<<D)-1];

    rf_wr_arbiter #(.W(W), .D(D), .N(N), .PRIV(2), .RSV0(14), .RSV1(15)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .stall       (stall),
        .ack         (ack),
        .err         (err),
        .rf_write_en (rf_write_en),
        .rf_waddr    (rf_waddr),
        .rf_data_in  (rf_data_in),
        .last_grant  (last_grant)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (rf_write_en === 1'b1) rf_mem[rf_waddr] <= rf_data_in;
    end

    // Scoreboard consumer: every ack pulse must match the oldest pushed expectation
    always @(negedge CLK) begin
        if (ack !== '0) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: ack=%b we=%b err=%b, expected no ack", ack, rf_write_en, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ack !== e.ack || rf_write_en !== e.we || err !== e.err ||
                    (e.we && (rf_waddr !== e.addr || rf_data_in !== e.data))) begin
                    failures++;
                    $display("FAIL scoreboard: ack=%b we=%b err=%b waddr=%0d data=%h, expected ack=%b we=%b err=%b waddr=%0d data=%h",
                             ack, rf_write_en, err, rf_waddr, rf_data_in, e.ack, e.we, e.err, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_slot(input int i, input logic [D-1:0] a, input logic [W-1:0] d);
        req_addr[i*D +: D] = a;
        req_data[i*W +: W] = d;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        req   = 3'b111;
        stall = 1'b0;
        for (int i = 0; i < N; i++) set_slot(i, 4'(i + 1), 8'(8'h11 * (i + 1)));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (ack !== 3'b000 || rf_write_en !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b we=%b err=%b, expected 000 0 0", ack, rf_write_en, err);
        end
        checks++;
        if (last_grant !== 2'd2) begin
            failures++;
            $display("FAIL reset_last_grant: got %0d, expected 2", last_grant);
        end
        checks++;
        if (rf_waddr !== 4'd0 || rf_data_in !== 8'h00) begin
            failures++;
            $display("FAIL reset_port: waddr=%0d data=%h, expected 0 00", rf_waddr, rf_data_in);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        sb.push_back('{3'b001, 1'b1, 1'b0, 4'd1, 8'h11});
        @(posedge CLK); #1;
        req = 3'b000;
        @(negedge CLK);
        checks++;
        if (last_grant !== 2'd0) begin
            failures++;
            $display("FAIL first_grant: last_grant=%0d, expected 0", last_grant);
        end
        @(posedge CLK);
    endtask

    task automatic test_single_write();
        @(posedge CLK); #1;
        req = 3'b010;
        set_slot(1, 4'd3, 8'hA5);
        sb.push_back('{3'b010, 1'b1, 1'b0, 4'd3, 8'hA5});
        @(posedge CLK); #1;
        req = 3'b000;
        @(negedge CLK);
        checks++;
        if (last_grant !== 2'd1) begin
            failures++;
            $display("FAIL single_last_grant: got %0d, expected 1", last_grant);
        end
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (rf_mem[3] !== 8'hA5 || rf_write_en !== 1'b0) begin
            failures++;
            $display("FAIL single_commit: reg3=%h we=%b, expected A5 0", rf_mem[3], rf_write_en);
        end
    endtask

    task automatic test_round_robin();
        @(posedge CLK); #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int i = 0; i < N; i++) set_slot(i, 4'(i + 4), 8'(8'h10 + i));
        for (int g = 0; g < 6; g++)
            sb.push_back('{3'(1 << (g % 3)), 1'b1, 1'b0, 4'((g % 3) + 4), 8'(8'h10 * (g / 3 + 1) + (g % 3))});
        req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            @(posedge CLK); #1;
            set_slot(g % 3, 4'((g % 3) + 4), 8'(8'h10 * (g / 3 + 2) + (g % 3)));
            if (g == 5) req = 3'b000;
            @(negedge CLK);
            checks++;
            if (rf_write_en !== 1'b1) begin
                failures++;
                $display("FAIL rr_continuous_we: grant %0d we=%b, expected 1", g, rf_write_en);
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (rf_write_en !== 1'b0 || ack !== 3'b000) begin
            failures++;
            $display("FAIL rr_drain: we=%b ack=%b, expected 0 000", rf_write_en, ack);
        end
    endtask

    task automatic test_reserved();
        @(posedge CLK); #1;
        req = 3'b001;
        set_slot(0, 4'd14, 8'h77);
        sb.push_back('{3'b001, 1'b0, 1'b1, 4'd14, 8'h77});
        @(posedge CLK); #1;
        req = 3'b100;
        set_slot(2, 4'd15, 8'h3C);
        sb.push_back('{3'b100, 1'b1, 1'b0, 4'd15, 8'h3C});
        @(posedge CLK); #1;
        req = 3'b000;
        @(posedge CLK); #1;
        req = 3'b010;
        set_slot(1, 4'd15, 8'h99);
        sb.push_back('{3'b010, 1'b0, 1'b1, 4'd15, 8'h99});
        @(posedge CLK); #1;
        req = 3'b000;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (rf_mem[14] !== 8'h00 || rf_mem[15] !== 8'h3C) begin
            failures++;
            $display("FAIL reserved_mem: reg14=%h reg15=%h, expected 00 3C", rf_mem[14], rf_mem[15]);
        end
    endtask

    task automatic test_stall();
        @(posedge CLK); #1;
        stall = 1'b1;
        req   = 3'b011;
        set_slot(0, 4'd7, 8'hA0);
        set_slot(1, 4'd8, 8'hA1);
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            checks++;
            if (ack !== 3'b000 || rf_write_en !== 1'b0) begin
                failures++;
                $display("FAIL stall_block: cycle %0d ack=%b we=%b, expected 000 0", c, ack, rf_write_en);
            end
        end
        stall = 1'b0;
        sb.push_back('{3'b001, 1'b1, 1'b0, 4'd7, 8'hA0});
        sb.push_back('{3'b010, 1'b1, 1'b0, 4'd8, 8'hA1});
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        req = 3'b000;
        @(posedge CLK); #1;
        // Grant taken just before stall rises must still complete; stall then forces IDLE
        req = 3'b011;
        set_slot(0, 4'd9, 8'h5A);
        sb.push_back('{3'b001, 1'b1, 1'b0, 4'd9, 8'h5A});
        @(posedge CLK); #1;
        stall = 1'b1;
        @(posedge CLK); #1;
        req = 3'b000;
        @(negedge CLK);
        checks++;
        if (ack !== 3'b000 || rf_write_en !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_issue: ack=%b we=%b, expected 000 0", ack, rf_write_en);
        end
        stall = 1'b0;
    endtask

    task automatic test_mid_reset();
        @(posedge CLK); #1;
        req = 3'b010;
        set_slot(1, 4'd6, 8'h66);
        sb.push_back('{3'b010, 1'b1, 1'b0, 4'd6, 8'h66});
        @(posedge CLK); #1;
        RST_N = 1'b0;
        req   = 3'b001;
        set_slot(0, 4'd2, 8'h22);
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (rf_write_en !== 1'b0 || ack !== 3'b000 || last_grant !== 2'd2) begin
            failures++;
            $display("FAIL mid_reset: we=%b ack=%b last_grant=%0d, expected 0 000 2", rf_write_en, ack, last_grant);
        end
        req = 3'b000;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drained: %0d expectations pending, expected 0", sb.size());
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << D); a++) rf_mem[a] = '0;
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_reserved();
        test_stall();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
